// File: rtl/div_bus_pkg.sv
// Shared definitions for the divider bus master: FSM states and the default
// divider register map, which the peripheral side also imports.
package div_bus_pkg;

  localparam logic [4:0] DIV_ADDR_A    = 5'h04;
  localparam logic [4:0] DIV_ADDR_B    = 5'h08;
  localparam logic [4:0] DIV_ADDR_INIT = 5'h0C;
  localparam logic [4:0] DIV_ADDR_RES  = 5'h10;
  localparam logic [4:0] DIV_ADDR_DONE = 5'h14;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_INIT1,
    ST_WR_INIT0,
    ST_SETTLE,
    ST_RD_DONE,
    ST_CAP_DONE,
    ST_GAP,
    ST_RD_RES,
    ST_CAP_RES,
    ST_FAIL
  } bus_state_e;

endpackage

// File: rtl/div_bus_wait_cnt.sv
// Loadable saturating down-counter; zero flags when the count has run out.
module div_bus_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/div_bus_master.sv
// Bus initiator for the divider peripheral: writes A/B, pulses init, polls
// done with a timeout and reads back the result word. All outputs registered.
module div_bus_master
  import div_bus_pkg::*;
#(
  parameter logic [4:0] ADDR_A     = DIV_ADDR_A,
  parameter logic [4:0] ADDR_B     = DIV_ADDR_B,
  parameter logic [4:0] ADDR_INIT  = DIV_ADDR_INIT,
  parameter logic [4:0] ADDR_RES   = DIV_ADDR_RES,
  parameter logic [4:0] ADDR_DONE  = DIV_ADDR_DONE,
  parameter int         SETTLE_CYC = 4,
  parameter int         POLL_GAP   = 2,
  parameter int         TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [31:0] result,
  output logic        cs,
  output logic [4:0]  addr,
  output logic        rd,
  output logic        wr,
  output logic [15:0] wdata,
  input  logic [31:0] rdata
);

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0]  GAP_LOAD    = 4'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LOAD   = 16'(TIMEOUT - 1);

  bus_state_e  state, state_next;
  logic [15:0] a_q, b_q, a_next, b_next;
  logic        cs_next, rd_next, wr_next;
  logic        busy_next, valid_next, error_next;
  logic [4:0]  addr_next;
  logic [15:0] wdata_next;
  logic [31:0] result_next;
  logic        wait_load, wait_dec, wait_zero;
  logic [3:0]  wait_val;
  logic        poll_load, poll_dec, poll_zero;

  div_bus_wait_cnt #(.W(4)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  // Counts remaining polls; loaded with TIMEOUT-1 as the first poll is issued.
  div_bus_wait_cnt #(.W(16)) u_poll_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (poll_load),
    .load_val (POLL_LOAD),
    .dec      (poll_dec),
    .zero     (poll_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cs     <= 1'b0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      a_q    <= a_next;
      b_q    <= b_next;
      cs     <= cs_next;
      rd     <= rd_next;
      wr     <= wr_next;
      addr   <= addr_next;
      wdata  <= wdata_next;
      busy   <= busy_next;
      valid  <= valid_next;
      error  <= error_next;
      result <= result_next;
    end
  end

  // Bus outputs are computed for the state being entered, so each access
  // appears on the bus exactly during that state's cycle.
  always_comb begin
    state_next  = state;
    a_next      = a_q;
    b_next      = b_q;
    cs_next     = 1'b0;
    rd_next     = 1'b0;
    wr_next     = 1'b0;
    addr_next   = '0;
    wdata_next  = wdata;
    busy_next   = busy;
    valid_next  = 1'b0;
    error_next  = 1'b0;
    result_next = result;
    wait_load   = 1'b0;
    wait_val    = SETTLE_LOAD;
    wait_dec    = 1'b0;
    poll_load   = 1'b0;
    poll_dec    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !valid && !error) begin
          a_next     = op_a;
          b_next     = op_b;
          busy_next  = 1'b1;
          state_next = ST_WR_A;
          cs_next    = 1'b1;
          wr_next    = 1'b1;
          addr_next  = ADDR_A;
          wdata_next = op_a;
        end
      end
      ST_WR_A: begin
        state_next = ST_WR_B;
        cs_next    = 1'b1;
        wr_next    = 1'b1;
        addr_next  = ADDR_B;
        wdata_next = b_q;
      end
      ST_WR_B: begin
        state_next = ST_WR_INIT1;
        cs_next    = 1'b1;
        wr_next    = 1'b1;
        addr_next  = ADDR_INIT;
        wdata_next = 16'h0001;
      end
      ST_WR_INIT1: begin
        state_next = ST_WR_INIT0;
        cs_next    = 1'b1;
        wr_next    = 1'b1;
        addr_next  = ADDR_INIT;
        wdata_next = 16'h0000;
      end
      ST_WR_INIT0: begin
        state_next = ST_SETTLE;
        wait_load  = 1'b1;
        wait_val   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (wait_zero) begin
          state_next = ST_RD_DONE;
          cs_next    = 1'b1;
          rd_next    = 1'b1;
          addr_next  = ADDR_DONE;
          poll_load  = 1'b1;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_RD_DONE: begin
        state_next = ST_CAP_DONE;
      end
      ST_CAP_DONE: begin
        if (rdata[0]) begin
          state_next = ST_RD_RES;
          cs_next    = 1'b1;
          rd_next    = 1'b1;
          addr_next  = ADDR_RES;
        end else if (poll_zero) begin
          state_next = ST_FAIL;
          error_next = 1'b1;
          busy_next  = 1'b0;
        end else if (POLL_GAP == 0) begin
          state_next = ST_RD_DONE;
          cs_next    = 1'b1;
          rd_next    = 1'b1;
          addr_next  = ADDR_DONE;
          poll_dec   = 1'b1;
        end else begin
          state_next = ST_GAP;
          wait_load  = 1'b1;
          wait_val   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (wait_zero) begin
          state_next = ST_RD_DONE;
          cs_next    = 1'b1;
          rd_next    = 1'b1;
          addr_next  = ADDR_DONE;
          poll_dec   = 1'b1;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_RD_RES: begin
        state_next = ST_CAP_RES;
      end
      ST_CAP_RES: begin
        state_next  = ST_IDLE;
        result_next = rdata;
        valid_next  = 1'b1;
        busy_next   = 1'b0;
      end
      ST_FAIL: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/div_bus_master.md
Name: div_bus_master

Overview:
Hardware initiator that drives the divider peripheral's register interface (cs/addr/rd/wr) on behalf of a non-CPU client. It takes one operand pair from a simple start/valid host port and runs the full bus sequence: write A, write B, pulse init, poll done, read result. It returns the raw 32-bit result word. It sits between a streaming datapath and the divider peripheral, in place of the femtorv32 core as bus master.

Parameters:
ADDR_A, 5'h04, register address of operand A
ADDR_B, 5'h08, register address of operand B
ADDR_INIT, 5'h0C, register address of init bit
ADDR_RES, 5'h10, register address of result
ADDR_DONE, 5'h14, register address of done flag
SETTLE_CYC, 4, idle cycles after init clear before first poll, so a stale done is never sampled (1..15)
POLL_GAP, 2, idle cycles between done polls (0..15)
TIMEOUT, 1023, maximum done polls before error (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  host request; sampled only in IDLE
op_a  in  16  dividend, captured on accepted start
op_b  in  16  divisor, captured on accepted start
busy  out  1  high from the cycle after start is accepted until return to IDLE
valid  out  1  one-cycle pulse; result is valid
error  out  1  one-cycle pulse; timeout expired
result  out  32  last read result word; held until the next valid
cs  out  1  peripheral chip select
addr  out  5  peripheral register address
rd  out  1  read strobe
wr  out  1  write strobe
wdata  out  16  write data, goes to the peripheral d_in
rdata  in  32  read data, comes from the peripheral d_out

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE
  - cs, rd, wr, busy, valid, error = 0
  - addr=0, wdata=0, result=0
  - all counters = 0
- Reset mid-transaction aborts immediately. Peripheral state is not cleaned up; the next operation rewrites A, B and init.
- All outputs are registered. Each bus access is exactly one cycle, with cs=1 and exactly one of rd/wr=1. Between accesses cs, rd and wr are 0.
- Peripheral read latency is 1 cycle: rdata is sampled on the cycle after the rd cycle.
- FSM states:
  - IDLE: if start, latch op_a/op_b, set busy, go to WR_A.
  - WR_A: addr=ADDR_A, wdata=A, then WR_B.
  - WR_B: addr=ADDR_B, wdata=B, then WR_INIT1.
  - WR_INIT1: addr=ADDR_INIT, wdata=16'h0001, then WR_INIT0.
  - WR_INIT0: addr=ADDR_INIT, wdata=16'h0000, then SETTLE. This produces a one-cycle init pulse.
  - SETTLE: idle SETTLE_CYC cycles, clear poll counter, then RD_DONE.
  - RD_DONE: addr=ADDR_DONE, rd=1, increment poll counter, then CAP_DONE.
  - CAP_DONE: bus idle. If rdata[0]=1, go to RD_RES. Else if poll counter == TIMEOUT, go to FAIL. Else go to GAP.
  - GAP: idle POLL_GAP cycles (0 means go straight to RD_DONE), then RD_DONE.
  - RD_RES: addr=ADDR_RES, rd=1, then CAP_RES.
  - CAP_RES: result <= rdata, valid=1 for this cycle, busy=0, then IDLE.
  - FAIL: error=1 for one cycle, busy=0, result unchanged, then IDLE.
- Minimum latency from start to valid is 8 + SETTLE_CYC cycles when done is seen on the first poll.
- start while busy is ignored, not queued. start in the same cycle as the valid/error pulse is ignored. It is accepted on the following cycle, when state is IDLE.
- op_b=0 is passed through unchecked. The result value is whatever the peripheral returns.
- rdata bits [31:1] are ignored during the done poll.

Decomposition:
- Shared package div_bus_pkg holds:
  - the FSM state enum
  - default register address constants, shared with the divider peripheral so both ends agree
- Optional sub-module div_bus_wait_cnt: loadable down-counter used for SETTLE, GAP and the poll/timeout count.
- Top-level FSM otherwise self-contained.

Test Plan:
- Reset, then start with op_a=100, op_b=7, bus model returns done=1 on first poll and result 32'h000E_0002 -> bus trace is exactly:
  - wr@04 with 0x0064
  - wr@08 with 0x0007
  - wr@0C with 1
  - wr@0C with 0
  - 4 idle cycles
  - rd@14
  - rd@10
  - then valid for one cycle with result=32'h000E_0002, 12 cycles after start.
- Model raises done only on the 3rd poll, POLL_GAP=2 -> exactly three rd@14 accesses, each separated by 1 capture + 2 gap cycles. valid follows the third poll's read of @10.
- TIMEOUT=4, done never set -> exactly 4 polls, then one-cycle error, result unchanged, busy=0, no rd@10 issued.
- start held high continuously across two operations -> the second operation begins the cycle after valid. No start is accepted while busy=1 (check operand changes mid-op are not captured).
- reset asserted during the poll phase (asynchronous, mid-cycle) -> cs/rd/wr/busy drop immediately without a clock edge. After release, a new start with op_a=9, op_b=3 completes normally.
- op_b=0 -> full bus sequence is issued unchanged. valid reports the model's value (e.g. 32'hFFFF_FFFF) with no error.
